// File: rtl/serial_frame_tx.sv
// serial_frame_tx: accepts a word over valid/ready and sends start, the low tx_len
// bits MSB-first, then finish. It also reports whether the sent value is divisible by 3.
`default_nettype none

module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             tx_data,
  input  logic [$clog2(WIDTH+1)-1:0]   tx_len,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         ser_out,
  output logic                         start,
  output logic                         finish,
  output logic                         busy,
  output logic                         exp_valid,
  output logic                         exp_div3
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [1:0]       rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             start_q, start_d;
  logic             finish_q, finish_d;
  logic             ser_q, ser_d;
  logic             expv_q, expv_d;
  logic             expd_q, expd_d;

  logic [LW-1:0]    len_c;
  logic [LW-1:0]    align_sh;
  logic [1:0]       rem_step;

  assign len_c    = (tx_len > LW'(WIDTH)) ? LW'(WIDTH) : tx_len;
  // Left-align the payload so the first bit to send always sits in the MSB.
  assign align_sh = LW'(WIDTH) - len_c;

  always_comb begin
    rem_step = 2'd0;
    case ({rem_q, ser_q})
      3'b000:  rem_step = 2'd0;
      3'b001:  rem_step = 2'd1;
      3'b010:  rem_step = 2'd2;
      3'b011:  rem_step = 2'd0;
      3'b100:  rem_step = 2'd1;
      3'b101:  rem_step = 2'd2;
      default: rem_step = 2'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    start_d  = 1'b0;
    finish_d = 1'b0;
    ser_d    = 1'b0;
    expv_d   = 1'b0;
    expd_d   = expd_q;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data << align_sh;
          cnt_d   = len_c;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START, S_DATA: begin
        rem_d = (state_q == S_START) ? 2'd0 : rem_step;
        if (cnt_q != '0) begin
          ser_d   = shift_q[WIDTH-1];
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - LW'(1);
          state_d = S_DATA;
        end else begin
          finish_d = 1'b1;
          state_d  = S_FINISH;
        end
      end
      S_FINISH: begin
        expv_d = 1'b1;
        expd_d = (rem_q == 2'd0);
        if (GAP > 0) begin
          gap_d   = GAP_LAST;
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      rem_q    <= 2'd0;
      gap_q    <= '0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      ser_q    <= 1'b0;
      expv_q   <= 1'b0;
      expd_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      start_q  <= start_d;
      finish_q <= finish_d;
      ser_q    <= ser_d;
      expv_q   <= expv_d;
      expd_q   <= expd_d;
    end
  end

  assign tx_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign start     = start_q;
  assign finish    = finish_q;
  assign ser_out   = ser_q;
  assign exp_valid = expv_q;
  assign exp_div3  = expd_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed and random frames checked against an arithmetic
// reference and a behavioural mod-3 receiver.
`default_nettype none

module tb_serial_frame_tx;

  logic       clk;
  logic       rst_n;

  logic [7:0] d1, d0;
  logic [3:0] n1, n0;
  logic       v1, v0;
  logic       rdy1, ser1, st1, fi1, bz1, ev1, ed1;
  logic       rdy0, ser0, st0, fi0, bz0, ev0, ed0;

  int n_chk;
  int n_pass;
  int n_fail;

  serial_frame_tx #(.WIDTH(8), .GAP(1)) u_dut_gap1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_len(n1), .tx_valid(v1),
    .tx_ready(rdy1), .ser_out(ser1), .start(st1), .finish(fi1), .busy(bz1),
    .exp_valid(ev1), .exp_div3(ed1)
  );

  serial_frame_tx #(.WIDTH(8), .GAP(0)) u_dut_gap0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_len(n0), .tx_valid(v0),
    .tx_ready(rdy0), .ser_out(ser0), .start(st0), .finish(fi0), .busy(bz0),
    .exp_valid(ev0), .exp_div3(ed0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One frame on the GAP=1 instance, checked cycle by cycle from cycle A+1 to A+L+4.
  task automatic run_frame(input logic [7:0] d, input logic [3:0] len);
    int l, val, rcv, bitv, w;
    l   = (int'(len) > 8) ? 8 : int'(len);
    val = int'(d) & ((1 << l) - 1);
    @(negedge clk);
    v1 = 1'b1; d1 = d; n1 = len;
    w = 0;
    while (!rdy1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", rdy1, 1);
    @(posedge clk);
    rcv = 0;
    for (int c = 1; c <= l + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        v1 = 1'b0; d1 = 8'($urandom); n1 = 4'($urandom);
      end
      bitv = (c >= 2 && c <= l + 1) ? ((val >> (l + 1 - c)) & 1) : 0;
      chk("ser_out", ser1, bitv);
      chk("start", st1, (c == 1));
      chk("finish", fi1, (c == l + 2));
      chk("exp_valid", ev1, (c == l + 3));
      chk("busy", bz1, (c <= l + 3));
      chk("tx_ready", rdy1, (c == l + 4));
      if (c >= 2 && c <= l + 1) rcv = rcv * 2 + int'(ser1);
      if (c == l + 3) begin
        chk("rx_value", rcv, val);
        chk("exp_div3", ed1, ((val % 3) == 0));
        chk("rx_vs_exp", ed1, ((rcv % 3) == 0));
      end
    end
  endtask

  initial begin
    int t_first, t_second, nexp;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    v1 = 1'b0; d1 = '0; n1 = '0;
    v0 = 1'b0; d0 = '0; n0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy1, 1);
    chk("rst_start", st1, 0);
    chk("rst_finish", fi1, 0);
    chk("rst_ser", ser1, 0);
    chk("rst_busy", bz1, 0);
    chk("rst_expv", ev1, 0);
    chk("rst_expd", ed1, 0);
    rst_n = 1'b1;

    // Directed frames
    run_frame(8'd6, 4'd8);
    run_frame(8'hF7, 4'd3);
    run_frame(8'h5A, 4'd0);
    run_frame(8'hA5, 4'd8);
    run_frame(8'hA5, 4'd12);
    run_frame(8'hFF, 4'd15);

    // Back-to-back on the GAP=0 instance with tx_valid held high
    @(negedge clk);
    v0 = 1'b1; d0 = 8'd3; n0 = 4'd8;
    t_first = -1; t_second = -1; nexp = 0;
    for (int c = 0; c < 60 && nexp < 2; c++) begin
      @(negedge clk);
      if (st0) begin
        if (t_first < 0) begin
          t_first = c; d0 = 8'd4;
        end else if (t_second < 0) begin
          t_second = c; v0 = 1'b0;
        end
      end
      if (ev0) begin
        if (nexp == 0) chk("b2b_div_first", ed0, 1);
        else           chk("b2b_div_second", ed0, 0);
        nexp++;
      end
    end
    v0 = 1'b0;
    chk("b2b_exp_count", nexp, 2);
    chk("b2b_period", t_second - t_first, 11);

    // Reset during the 4th data bit
    @(negedge clk);
    v1 = 1'b1; d1 = 8'hB6; n1 = 4'd8;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_ser_bit3", ser1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ser", ser1, 0);
    chk("arst_busy", bz1, 0);
    chk("arst_ready", rdy1, 1);
    chk("arst_start", st1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_finish", fi1, 0);
      chk("arst_no_expv", ev1, 0);
    end
    rst_n = 1'b1;
    run_frame(8'd9, 4'd8);

    // Closed loop with random words and lengths
    for (int i = 0; i < 500; i++) begin
      run_frame(8'($urandom), 4'($urandom_range(0, 10)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
